serial_magnitude_comparator: RTL and testbench

- Bit-serial unsigned magnitude comparator for two WIDTH-bit operands.
- Accepts an operand pair over a valid/ready handshake and scans it MSB-first, one bit per cycle, using 1-bit equal/less/greater compare logic.
- Returns a one-hot eq/lt/gt result over a second valid/ready handshake.
- Sits downstream of the 1-bit comparator cell as its multi-bit sequential consumer.

---
 rtl/serial_magnitude_comparator.sv | 166 ++++++++++++++++
 tb/tb_serial_magnitude_comparator.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/serial_magnitude_comparator.sv
// serial_magnitude_comparator
//   Bit-serial unsigned magnitude comparator. An operand pair (a, b) is
//   accepted over a valid/ready handshake. It is scanned MSB-first, one bit
//   per cycle. A one-hot eq/lt/gt result is then returned over a second
//   valid/ready handshake.
//
//   Optional feature macro: SERIAL_CMP_EARLY_TERM_EN
//     defined     : the scan stops at the first differing bit (latency 1..WIDTH)
//     not defined : the scan always covers all WIDTH bits (latency WIDTH)
//   Both builds produce the same result flags.
//
// Ports
//   clk, rst_n           rising-edge clock, asynchronous active-low reset
//   in_valid / in_ready  operand handshake; in_ready is high only in IDLE
//   a, b                 WIDTH-bit unsigned operands
//   out_valid/out_ready  result handshake; out_valid is high only in DONE
//   a_eq_b/a_lt_b/a_gt_b one-hot result; all are 0 while out_valid is 0
//   busy                 high while in SCAN or DONE
//
// State | meaning
//   IDLE | waiting for an operand pair
//   SCAN | comparing one bit per cycle, MSB first
//   DONE | result held until downstream takes it

module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic             a_eq_b,
  output logic             a_lt_b,
  output logic             a_gt_b,
  output logic             busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_SCAN = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             diff_q, diff_d;   // a difference has been recorded
  logic             rlt_q, rlt_d;     // recorded difference says A < B
  logic             eq_q, eq_d;
  logic             lt_q, lt_d;
  logic             gt_q, gt_d;
  logic             ov_q, ov_d;
  logic             bit_ne;
  logic             scan_exit;

  always_comb begin
    state_d   = state_q;
    sa_d      = sa_q;
    sb_d      = sb_q;
    cnt_d     = cnt_q;
    diff_d    = diff_q;
    rlt_d     = rlt_q;
    eq_d      = eq_q;
    lt_d      = lt_q;
    gt_d      = gt_q;
    ov_d      = ov_q;
    bit_ne    = sa_q[WIDTH-1] ^ sb_q[WIDTH-1];
    scan_exit = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          sa_d    = a;
          sb_d    = b;
          cnt_d   = CW'(WIDTH - 1);
          diff_d  = 1'b0;
          rlt_d   = 1'b0;
          state_d = ST_SCAN;
        end
      end

      ST_SCAN: begin
        // Only the first difference counts; later ones cannot overwrite it.
        if (bit_ne && !diff_q) begin
          diff_d = 1'b1;
          rlt_d  = ~sa_q[WIDTH-1];
        end
        sa_d  = {sa_q[WIDTH-2:0], 1'b0};
        sb_d  = {sb_q[WIDTH-2:0], 1'b0};
        cnt_d = cnt_q - CW'(1);
`ifdef SERIAL_CMP_EARLY_TERM_EN
        scan_exit = bit_ne || (cnt_q == '0);
`else
        scan_exit = (cnt_q == '0);
`endif
        if (scan_exit) begin
          cnt_d   = cnt_q;            // hold at exit rather than wrap
          eq_d    = ~diff_d;
          lt_d    = diff_d & rlt_d;
          gt_d    = diff_d & ~rlt_d;
          ov_d    = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (out_ready) begin
          eq_d    = 1'b0;
          lt_d    = 1'b0;
          gt_d    = 1'b0;
          ov_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end

      default: begin
        eq_d    = 1'b0;
        lt_d    = 1'b0;
        gt_d    = 1'b0;
        ov_d    = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      cnt_q   <= '0;
      diff_q  <= 1'b0;
      rlt_q   <= 1'b0;
      eq_q    <= 1'b0;
      lt_q    <= 1'b0;
      gt_q    <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      rlt_q   <= rlt_d;
      eq_q    <= eq_d;
      lt_q    <= lt_d;
      gt_q    <= gt_d;
      ov_q    <= ov_d;
    end
  end

  assign in_ready  = (state_q == ST_IDLE);
  assign busy      = (state_q == ST_SCAN) || (state_q == ST_DONE);
  assign out_valid = ov_q;
  assign a_eq_b    = eq_q;
  assign a_lt_b    = lt_q;
  assign a_gt_b    = gt_q;

endmodule

// File: tb/tb_serial_magnitude_comparator.sv
module tb_serial_magnitude_comparator;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;
  logic         out_valid;
  logic         out_ready = 1'b1;
  logic         a_eq_b, a_lt_b, a_gt_b;
  logic         busy;

  int total = 0;
  int bad   = 0;
  int n_results = 0;

  serial_magnitude_comparator #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b),
    .out_valid(out_valid), .out_ready(out_ready),
    .a_eq_b(a_eq_b), .a_lt_b(a_lt_b), .a_gt_b(a_gt_b),
    .busy(busy)
  );

  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  // result code: 1 = eq, 2 = lt, 4 = gt  (maps to {gt,lt,eq})
  function automatic logic [2:0] model_res(input logic [W-1:0] x, input logic [W-1:0] y);
    if (x == y) return 3'b001;
    if (x < y)  return 3'b010;
    return 3'b100;
  endfunction

  function automatic int model_lat(input logic [W-1:0] x, input logic [W-1:0] y);
    int p;
    p = -1;
    for (int i = 0; i < W; i++) if (x[i] != y[i]) p = i;
`ifdef SERIAL_CMP_EARLY_TERM_EN
    if (p < 0) return W;
    return W - p;
`else
    if (p < -1) return 0;
    return W;
`endif
  endfunction

  int         m_rem  = 0;     // cycles left until the result appears
  bit         m_done = 1'b0;  // result being presented
  logic [2:0] m_res  = 3'b000;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_rem  <= 0;
      m_done <= 1'b0;
      m_res  <= 3'b000;
    end else if (m_done) begin
      if (out_ready) m_done <= 1'b0;
    end else if (m_rem > 0) begin
      m_rem <= m_rem - 1;
      if (m_rem == 1) m_done <= 1'b1;
    end else if (in_valid) begin
      m_rem <= model_lat(a, b);
      m_res <= model_res(a, b);
    end
  end

  // One compare per cycle over every output.
  always @(negedge clk) begin
    logic       idle;
    logic [5:0] exp_v, got_v;
    idle  = !m_done && (m_rem == 0);
    exp_v = {idle, !idle, m_done, m_done ? m_res : 3'b000};
    got_v = {in_ready, busy, out_valid, a_gt_b, a_lt_b, a_eq_b};
    total++;
    if (got_v !== exp_v) begin
      bad++;
      $display("FAIL cycle_check t=%0t {rdy,busy,ov,gt,lt,eq} got=%b want=%b", $time, got_v, exp_v);
    end
    if (out_valid && out_ready) n_results++;
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int got, input int want);
    total++;
    if (got != want) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", name, got, want);
    end
  endtask

  task automatic send(input logic [W-1:0] x, input logic [W-1:0] y, output bit ok);
    ok = 1'b0;
    a = x; b = y; in_valid = 1'b1;
    for (int i = 0; i < 30 && !ok; i++) begin
      if (in_ready) ok = 1'b1;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (!ok) chk("send_timeout", 0, 1);
  endtask

  task automatic wait_result(output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(posedge clk); #1;
      if (out_valid) begin lat = n; break; end
    end
    if (lat < 0) chk("result_timeout", 0, 1);
  endtask

  task automatic run_pair(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [2:0] want_flags, input int want_lat);
    bit ok;
    int lat;
    send(x, y, ok);
    if (ok) begin
      wait_result(lat);
      chk({name, "_lat"}, lat, want_lat);
      chk({name, "_flags"}, int'({a_gt_b, a_lt_b, a_eq_b}), int'(want_flags));
      @(posedge clk); #1;   // out_ready is high: result consumed here
    end
  endtask

  int lat_80_7f, lat_10_20, lat_11_22;

  initial begin
    bit ok;
    int lat;
`ifdef SERIAL_CMP_EARLY_TERM_EN
    lat_80_7f = 1; lat_10_20 = 3; lat_11_22 = 3;
`else
    lat_80_7f = 8; lat_10_20 = 8; lat_11_22 = 8;
`endif
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_flags", int'({a_gt_b, a_lt_b, a_eq_b}), 0);
    chk("rst_busy", int'(busy), 0);
    chk("rst_in_ready", int'(in_ready), 1);

    run_pair("equal_a5", 8'hA5, 8'hA5, 3'b001, 8);
    run_pair("msb_diff", 8'h80, 8'h7F, 3'b100, lat_80_7f);
    run_pair("lsb_diff", 8'h3C, 8'h3D, 3'b010, 8);

    // Backpressure: result held, new pair offered but not taken.
    out_ready = 1'b0;
    send(8'h80, 8'h7F, ok);
    wait_result(lat);
    a = 8'h11; b = 8'h22; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("bp_flags", int'({out_valid, a_gt_b, a_lt_b, a_eq_b}), 4'b1100);
      chk("bp_in_ready", int'(in_ready), 0);
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release_idle", int'({in_ready, out_valid}), 2'b10);
    @(posedge clk); #1;
    chk("bp_next_accepted", int'({in_ready, busy}), 2'b01);
    in_valid = 1'b0;
    wait_result(lat);
    chk("bp_next_lat", lat, lat_11_22);
    chk("bp_next_flags", int'({a_gt_b, a_lt_b, a_eq_b}), 3'b010);
    @(posedge clk); #1;

    // Reset in the middle of a scan.
    send(8'h01, 8'h00, ok);
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("midrst_outputs", int'({in_ready, busy, out_valid, a_gt_b, a_lt_b, a_eq_b}), 6'b100000);
    @(posedge clk); #1 rst_n = 1'b1;
    run_pair("after_rst", 8'h10, 8'h20, 3'b010, lat_10_20);

    // Randomized traffic checked by the cycle model.
    for (int c = 0; c < 3000; c++) begin
      logic [W-1:0] ra;
      ra = W'($urandom);
      in_valid  = ($urandom % 3) != 0;
      out_ready = ($urandom % 4) != 0;
      a = ra;
      case ($urandom % 3)
        0: b = ra;
        1: b = ra ^ (W'(1) << ($urandom % W));
        default: b = W'($urandom);
      endcase
      @(posedge clk); #1;
    end
    in_valid = 1'b0; out_ready = 1'b1;
    repeat (12) @(posedge clk);
    #1;
    total++;
    if (n_results < 50) begin
      bad++;
      $display("FAIL random_results got=%0d want>=50", n_results);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
